// File: rtl/sao_bo_stat_ctrl_if.sv
// Beat-level link between the SAO band-offset statistics controller and the
// reconstruction buffer / statistics accumulator it steers.
interface sao_bo_stat_ctrl_if #(
  parameter int unsigned N_PIX    = 4,
  parameter int unsigned CTU_LOG2 = 5
);
  logic                pix_vld_i;
  logic                stall_i;
  logic                en_o;
  logic [1:0]          cidx_o;
  logic [N_PIX-1:0]    b_use_o;
  logic                not_end_o;
  logic                wait_forpre_o;
  logic                refresh_o;
  logic [CTU_LOG2-1:0] x_o;
  logic [CTU_LOG2-1:0] y_o;

  // Controller side
  modport master (
    input  pix_vld_i, stall_i,
    output en_o, cidx_o, b_use_o, not_end_o, wait_forpre_o, refresh_o, x_o, y_o
  );

  // Buffer / accumulator side
  modport slave (
    output pix_vld_i, stall_i,
    input  en_o, cidx_o, b_use_o, not_end_o, wait_forpre_o, refresh_o, x_o, y_o
  );
endinterface

// File: rtl/sao_bo_stat_ctrl.sv
// Sequences band-offset statistics collection over one CTU: Y, Cb, Cr scanned
// in N_PIX-wide beats, each preceded by an accumulator refresh and followed by a pipeline drain.
module sao_bo_stat_ctrl #(
  parameter int unsigned N_PIX    = 4,
  parameter int unsigned CTU_LOG2 = 5,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [CTU_LOG2:0]   ctu_w_i,
  input  logic [CTU_LOG2:0]   ctu_h_i,
  sao_bo_stat_ctrl_if.master  pix_if,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned DW = CTU_LOG2 + 1;
  localparam int unsigned PW = CTU_LOG2 + 2;
  localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFRESH,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cidx_q, cidx_d;
  logic [CTU_LOG2-1:0] x_q, x_d;
  logic [CTU_LOG2-1:0] y_q, y_d;
  logic [DW-1:0]       w_q, w_d;
  logic [DW-1:0]       h_q, h_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [DW-1:0]       comp_w_c;
  logic [DW-1:0]       comp_h_c;
  logic [PW-1:0]       x_next_c;
  logic                last_col_c;
  logic                last_row_c;
  logic [N_PIX-1:0]    b_use_c;

  logic                en_c;
  logic                refresh_c;
  logic                not_end_c;
  logic                wait_c;
  logic [N_PIX-1:0]    b_use_out_c;
  logic                busy_c;
  logic                done_c;

  // Chroma planes are 4:2:0 subsampled, rounding odd luma sizes up
  always_comb begin
    comp_w_c = w_q;
    comp_h_c = h_q;
    if (cidx_q != 2'd0) begin
      comp_w_c = DW'((PW'(w_q) + PW'(1)) >> 1);
      comp_h_c = DW'((PW'(h_q) + PW'(1)) >> 1);
    end
  end

  assign x_next_c   = PW'(x_q) + PW'(N_PIX);
  assign last_col_c = (x_next_c >= PW'(comp_w_c));
  assign last_row_c = (PW'(y_q) == (PW'(comp_h_c) - PW'(1)));

  always_comb begin
    b_use_c = '0;
    for (int unsigned i = 0; i < N_PIX; i++) begin
      b_use_c[i] = ((PW'(x_q) + PW'(i)) < PW'(comp_w_c));
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cidx_d      = cidx_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    cnt_d       = cnt_q;
    en_c        = 1'b0;
    refresh_c   = 1'b0;
    not_end_c   = 1'b0;
    wait_c      = 1'b0;
    b_use_out_c = '0;
    busy_c      = 1'b1;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (start_i) begin
          state_d = ST_REFRESH;
          cidx_d  = 2'd0;
          x_d     = '0;
          y_d     = '0;
          w_d     = ctu_w_i;
          h_d     = ctu_h_i;
        end
      end

      ST_REFRESH: begin
        refresh_c = 1'b1;
        x_d       = '0;
        y_d       = '0;
        state_d   = ST_SCAN;
      end

      ST_SCAN: begin
        en_c        = pix_if.pix_vld_i & ~pix_if.stall_i;
        wait_c      = ~pix_if.pix_vld_i;
        b_use_out_c = b_use_c;
        not_end_c   = ~(last_col_c & last_row_c);
        if (en_c) begin
          if (last_col_c) begin
            x_d = '0;
            if (last_row_c) begin
              y_d     = '0;
              cnt_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + CTU_LOG2'(1);
            end
          end else begin
            x_d = CTU_LOG2'(x_next_c);
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_q == CW'(PIPE_LAT - 1)) begin
          if (cidx_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            cidx_d  = cidx_q + 2'd1;
            state_d = ST_REFRESH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the synchronous clear aborts a CTU without a done pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cidx_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cnt_q   <= '0;
    end else if (!rst_n) begin
      state_q <= ST_IDLE;
      cidx_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pix_if.en_o          = en_c;
  assign pix_if.cidx_o        = cidx_q;
  assign pix_if.b_use_o       = b_use_out_c;
  assign pix_if.not_end_o     = not_end_c;
  assign pix_if.wait_forpre_o = wait_c;
  assign pix_if.refresh_o     = refresh_c;
  assign pix_if.x_o           = x_q;
  assign pix_if.y_o           = y_q;
  assign busy_o               = busy_c;
  assign done_o               = done_c;

endmodule

// File: tb/tb_sao_bo_stat_ctrl.sv
// Scoreboard bench for sao_bo_stat_ctrl: stimulus queues expected beats,
// refreshes and done pulses; a negedge monitor pops and compares them.
module tb_sao_bo_stat_ctrl;
  localparam int unsigned N_PIX    = 4;
  localparam int unsigned CTU_LOG2 = 5;
  localparam int unsigned PIPE_LAT = 2;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0;
  logic [5:0] ctu_w_i = '0;
  logic [5:0] ctu_h_i = '0;
  logic       busy_o;
  logic       done_o;

  sao_bo_stat_ctrl_if #(.N_PIX(N_PIX), .CTU_LOG2(CTU_LOG2)) pix_if ();

  sao_bo_stat_ctrl #(.N_PIX(N_PIX), .CTU_LOG2(CTU_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .rst_n   (rst_n),
    .start_i (start_i),
    .ctu_w_i (ctu_w_i),
    .ctu_h_i (ctu_h_i),
    .pix_if  (pix_if),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] c;
    logic [4:0] x;
    logic [4:0] y;
    logic [3:0] bu;
    logic       ne;
  } beat_t;

  beat_t      beat_q[$];
  logic [1:0] ref_q[$];
  int         done_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_en_cyc = 0;
  int en_cnt[3] = '{0, 0, 0};
  int ref_cnt = 0;
  int done_cnt = 0;
  int wait_cnt = 0;
  logic [3:0] luma_edge_bu = '0;
  logic [3:0] cb_edge_bu = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference beat sequence for a whole CTU
  task automatic push_ctu(input int w, input int h);
    beat_t b;
    int cw, ch;
    for (int c = 0; c < 3; c++) begin
      cw = (c == 0) ? w : (w + 1) / 2;
      ch = (c == 0) ? h : (h + 1) / 2;
      ref_q.push_back(2'(c));
      for (int y = 0; y < ch; y++) begin
        for (int x = 0; x < cw; x += N_PIX) begin
          b.c = 2'(c);
          b.x = 5'(x);
          b.y = 5'(y);
          for (int i = 0; i < 4; i++) b.bu[i] = ((x + i) < cw);
          b.ne = !(((x + 4) >= cw) && (y == ch - 1));
          beat_q.push_back(b);
        end
      end
    end
    done_q.push_back(1);
  endtask

  task automatic start_ctu(input int w, input int h);
    push_ctu(w, h);
    @(posedge clk); #1;
    ctu_w_i = 6'(w);
    ctu_h_i = 6'(h);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    ctu_w_i = 6'd3;
    ctu_h_i = 6'd3;
  endtask

  // mode 0: clean; 1: random stall / valid gaps; 2: clean plus start pulse during DONE
  task automatic wait_done(input int mode, input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      if (mode == 1) begin
        pix_if.stall_i   = ($urandom_range(0, 1) == 1);
        pix_if.pix_vld_i = ($urandom_range(0, 3) != 0);
      end
      start_i = (mode == 2) && done_o;
      if (start_i) begin
        ctu_w_i = 6'd20;
        ctu_h_i = 6'd20;
      end
      @(posedge clk); #1;
      k++;
    end
    start_i          = 1'b0;
    pix_if.stall_i   = 1'b0;
    pix_if.pix_vld_i = 1'b1;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard
  initial forever begin
    beat_t got;
    @(negedge clk);
    if (arst_n) begin
      if (pix_if.stall_i || !pix_if.pix_vld_i) chk("en_blocked", pix_if.en_o, 0);
      if (pix_if.wait_forpre_o) wait_cnt++;
      if (pix_if.en_o) begin
        got = {pix_if.cidx_o, pix_if.x_o, pix_if.y_o, pix_if.b_use_o, pix_if.not_end_o};
        if (beat_q.size() == 0) chk("beat_unexpected", longint'(got), 0);
        else chk("beat", longint'(got), longint'(beat_q.pop_front()));
        if (pix_if.cidx_o < 2'd3) en_cnt[pix_if.cidx_o]++;
        last_en_cyc = cyc;
        if (pix_if.cidx_o == 2'd0 && pix_if.x_o == 5'd16) luma_edge_bu = pix_if.b_use_o;
        if (pix_if.cidx_o == 2'd1 && pix_if.x_o == 5'd8) cb_edge_bu = pix_if.b_use_o;
      end
      if (pix_if.refresh_o) begin
        ref_cnt++;
        if (ref_q.size() == 0) chk("refresh_unexpected", 1, 0);
        else chk("refresh_cidx", pix_if.cidx_o, ref_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        chk("done_latency", cyc - last_en_cyc, PIPE_LAT + 1);
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else void'(done_q.pop_front());
      end
    end
  end

  initial begin
    int e0[3];
    int r0, d0, w0, k;

    pix_if.pix_vld_i = 1'b1;
    pix_if.stall_i   = 1'b0;
    start_i          = 1'b1;

    // Asynchronous reset holds everything idle even with start asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cidx", pix_if.cidx_o, 0);
    chk("rst_x", pix_if.x_o, 0);
    chk("rst_y", pix_if.y_o, 0);
    chk("rst_buse", pix_if.b_use_o, 0);
    chk("rst_en", pix_if.en_o, 0);
    chk("rst_not_end", pix_if.not_end_o, 0);
    chk("rst_wait", pix_if.wait_forpre_o, 0);
    chk("rst_refresh", pix_if.refresh_o, 0);
    start_i = 1'b0;
    arst_n  = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy_o, 0);

    // Full 32x32 CTU, continuous valid
    e0 = en_cnt; r0 = ref_cnt; d0 = done_cnt; w0 = wait_cnt;
    start_ctu(32, 32);
    chk("busy_running", busy_o, 1);
    wait_done(0, 2000);
    chk("full_en_y", en_cnt[0] - e0[0], 256);
    chk("full_en_cb", en_cnt[1] - e0[1], 64);
    chk("full_en_cr", en_cnt[2] - e0[2], 64);
    chk("full_refresh", ref_cnt - r0, 3);
    chk("full_done", done_cnt - d0, 1);
    chk("full_wait", wait_cnt - w0, 0);
    chk("full_idle_busy", busy_o, 0);

    // 18x10 boundary CTU under random stall and valid gaps
    e0 = en_cnt; d0 = done_cnt;
    start_ctu(18, 10);
    wait_done(1, 3000);
    chk("bnd_en_y", en_cnt[0] - e0[0], 50);
    chk("bnd_en_cb", en_cnt[1] - e0[1], 15);
    chk("bnd_en_cr", en_cnt[2] - e0[2], 15);
    chk("bnd_luma_edge_buse", luma_edge_bu, 4'b0011);
    chk("bnd_cb_edge_buse", cb_edge_bu, 4'b0001);
    chk("bnd_done", done_cnt - d0, 1);

    // 8x4 CTU: 5-cycle valid gap mid-row, start pulses in SCAN and DONE
    e0 = en_cnt; d0 = done_cnt;
    start_ctu(8, 4);
    k = 0;
    while (en_cnt[0] - e0[0] < 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("gap_reach", en_cnt[0] - e0[0], 3);
    pix_if.pix_vld_i = 1'b0;
    w0 = wait_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("gap_x", pix_if.x_o, 4);
      chk("gap_y", pix_if.y_o, 1);
      start_i = (i == 2);
      if (i == 2) begin
        ctu_w_i = 6'd20;
        ctu_h_i = 6'd20;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    chk("gap_wait_cycles", wait_cnt - w0, 5);
    pix_if.pix_vld_i = 1'b1;
    wait_done(2, 500);
    chk("ign_idle_busy", busy_o, 0);
    @(posedge clk); #1;
    chk("ign_still_idle", busy_o, 0);
    chk("ign_single_done", done_cnt - d0, 1);
    chk("ign_beats_left", beat_q.size(), 0);

    // Synchronous clear during Cb scan
    d0 = done_cnt;
    start_ctu(8, 4);
    k = 0;
    while (!(pix_if.cidx_o == 2'd1 && pix_if.b_use_o != 4'd0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_in_cb", pix_if.cidx_o, 1);
    pix_if.pix_vld_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy_o, 0);
    chk("abort_cidx", pix_if.cidx_o, 0);
    chk("abort_x", pix_if.x_o, 0);
    chk("abort_y", pix_if.y_o, 0);
    chk("abort_beats_left", beat_q.size(), 4);
    chk("abort_refresh_left", ref_q.size(), 1);
    beat_q.delete();
    ref_q.delete();
    done_q.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    pix_if.pix_vld_i = 1'b1;
    start_ctu(8, 4);
    wait_done(0, 500);
    chk("after_abort_done", done_cnt - d0, 1);

    // 1x1 CTU: one final beat per component
    e0 = en_cnt;
    start_ctu(1, 1);
    wait_done(0, 200);
    chk("one_en_y", en_cnt[0] - e0[0], 1);
    chk("one_en_cb", en_cnt[1] - e0[1], 1);
    chk("one_en_cr", en_cnt[2] - e0[2], 1);
    chk("end_beats_left", beat_q.size(), 0);
    chk("end_refresh_left", ref_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
